// File: rtl/riscv.sv
// riscv: shared rv32cpu instruction field types, operand selects and opcode constants.
package riscv;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;
    typedef logic [4:0] reg_t;

    typedef struct packed {
        funct7_t funct7;
        reg_t    rs2;
        reg_t    rs1;
        funct3_t funct3;
        reg_t    rd;
        opcode_t opcode;
    } ir_t;

    typedef enum logic {
        OP1_RS1,
        OP1_PC
    } op1_sel_t;

    typedef enum logic [2:0] {
        OP2_RS2,
        OP2_I_IMM,
        OP2_S_IMM,
        OP2_B_IMM,
        OP2_U_IMM,
        OP2_J_IMM,
        OP2_FOUR
    } op2_sel_t;

    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: RISC-V I/S/B/U/J immediates, sign-extended from instruction bit 31 to XLEN.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_ir,
    output logic [XLEN-1:0] o_imm_i,
    output logic [XLEN-1:0] o_imm_s,
    output logic [XLEN-1:0] o_imm_b,
    output logic [XLEN-1:0] o_imm_u,
    output logic [XLEN-1:0] o_imm_j
);

    // Signed casts do the sign extension without zero-width replications at XLEN=32.
    assign o_imm_i = XLEN'($signed(i_ir[31:20]));
    assign o_imm_s = XLEN'($signed({i_ir[31:25], i_ir[11:7]}));
    assign o_imm_b = XLEN'($signed({i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0}));
    assign o_imm_u = XLEN'($signed({i_ir[31:12], 12'b0}));
    assign o_imm_j = XLEN'($signed({i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0}));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with forwarding, load-use stall and a one-entry valid/ready output buffer.
module decode_stage
    import riscv::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  ir_t               ir,
    input  op1_sel_t          op1_sel,
    input  op2_sel_t          op2_sel,
    output reg_t              raddr1,
    output reg_t              raddr2,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic [NFWD-1:0]   fwd_valid,
    input  logic [NFWD*5-1:0] fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic              ex_load,
    input  reg_t              ex_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output opcode_t           opcode,
    output funct3_t           funct3,
    output funct7_t           funct7,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   rs2,
    output reg_t              rd
);

    typedef logic [XLEN-1:0] xword_t;
    typedef enum logic {EMPTY, FULL} state_t;

    state_t r_state, w_state_nxt;
    xword_t w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    xword_t w_src1, w_src2, w_op1, w_op2;
    logic   w_use1, w_use2, w_hazard, w_advance, w_load;

    // Descending scan so the lowest matching index wins; x0 always reads zero.
    function automatic xword_t resolve(input reg_t a, input xword_t rf, input logic [NFWD-1:0] v,
                                       input logic [NFWD*5-1:0] frd, input logic [NFWD*XLEN-1:0] fd);
        resolve = rf;
        for (int k = NFWD - 1; k >= 0; k--)
            if (v[k] && frd[k*5 +: 5] == a) resolve = fd[k*XLEN +: XLEN];
        if (a == '0) resolve = '0;
    endfunction

    imm_gen #(.XLEN(XLEN)) u_imm (
        .i_ir    (ir[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    assign raddr1 = ir.rs1;
    assign raddr2 = ir.rs2;
    assign w_src1 = resolve(ir.rs1, rdata1, fwd_valid, fwd_rd, fwd_data);
    assign w_src2 = resolve(ir.rs2, rdata2, fwd_valid, fwd_rd, fwd_data);

    assign w_op1 = (op1_sel == OP1_RS1) ? w_src1 : pc;

    always_comb begin
        w_op2 = w_src2;
        case (op2_sel)
            OP2_I_IMM: w_op2 = w_imm_i;
            OP2_S_IMM: w_op2 = w_imm_s;
            OP2_B_IMM: w_op2 = w_imm_b;
            OP2_U_IMM: w_op2 = w_imm_u;
            OP2_J_IMM: w_op2 = w_imm_j;
            OP2_FOUR:  w_op2 = XLEN'(4);
            default:   w_op2 = w_src2;
        endcase
    end

    assign w_use1    = op1_sel == OP1_RS1;
    assign w_use2    = op2_sel == OP2_RS2 || ir.opcode == OP_STORE || ir.opcode == OP_BRANCH;
    assign w_hazard  = ex_load && ex_rd != '0 &&
                       ((w_use1 && ex_rd == ir.rs1) || (w_use2 && ex_rd == ir.rs2));
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = flush || (w_advance && !w_hazard);
    assign w_load    = !flush && w_advance && in_valid && !w_hazard;
    assign out_valid = r_state == FULL;

    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = EMPTY;
        else if (w_advance)
            w_state_nxt = (in_valid && !w_hazard) ? FULL : EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            out_pc  <= '0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= '0;
            op1     <= '0;
            op2     <= '0;
            rs2     <= '0;
            rd      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                out_pc <= pc;
                opcode <= ir.opcode;
                funct3 <= ir.funct3;
                funct7 <= ir.funct7;
                op1    <= w_op1;
                op2    <= w_op2;
                rs2    <= w_src2;
                rd     <= ir.rd;
            end
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked instruction-decode stage for the rv32cpu pipeline, placed between fetch and execute. It splits the instruction word, generates the sign-extended immediates, and reads the register file. It resolves source operands through a prioritised forwarding network, detects load-use hazards, and registers the decoded operands into a one-entry output buffer with valid/ready flow control and flush. XLEN and the number of forwarding sources are parameters.

## Interface
- XLEN, 32, datapath width (32 or 64)
- NFWD, 2, number of forwarding sources; index 0 has highest priority
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers pc/ir
- in_ready  out  1  stage accepts pc/ir this cycle
- pc  in  XLEN  instruction address
- ir  in  32  instruction word (ir_t)
- op1_sel  in  op1_sel_t  RS1 or PC
- op2_sel  in  op2_sel_t  RS2, I_IMM, S_IMM, B_IMM, U_IMM, J_IMM, FOUR
- raddr1, raddr2  out  5 each  register-file read addresses (ir rs1/rs2, combinational)
- rdata1, rdata2  in  XLEN each  register-file read data, same cycle
- fwd_valid  in  NFWD  forwarding source valid
- fwd_rd  in  NFWD*5  forwarding destination registers
- fwd_data  in  NFWD*XLEN  forwarding values
- ex_load  in  1  instruction in execute is a load
- ex_rd  in  5  its destination register
- flush  in  1  kill buffered and incoming instruction
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  registered pc
- opcode, funct3, funct7  out  opcode_t, funct3_t, funct7_t  registered fields
- op1, op2, rs2  out  XLEN each  registered operands; rs2 is the forwarded store/branch value
- rd  out  5  registered destination

## Operation
- Immediates: I, S, B, U, J per RV spec, sign-extended from the top instruction bit to XLEN. B and J have bit 0 = 0. U has [11:0] = 0. FOUR = 4.
- Source resolution per operand (src1 from rs1, src2 from rs2):
  - if the address is 0, the value is 0;
  - else the lowest index i with fwd_valid[i] && fwd_rd[i]==address supplies fwd_data[i];
  - else rdata.
- op1 = src1 if op1_sel==RS1, else pc. op2 = mux(op2_sel) with RS2 → src2. rs2 output = src2 always.
- rs1 is used when op1_sel==RS1. rs2 is used when op2_sel==RS2 or opcode is STORE or BRANCH.
- hazard = ex_load && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)).
- advance = !out_valid || out_ready.
- in_ready = flush || (advance && !hazard).
- Next-state priority:
  - rst: out_valid=0.
  - flush: out_valid=0; any concurrent input transfer is discarded.
  - advance: out_valid=in_valid && !hazard. Payload loads only when in_valid && !hazard; with hazard, a bubble is inserted.
  - else: hold all outputs.
- Buffer states: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY→FULL on an accepted input. FULL→EMPTY on out_ready with no accepted input, or on flush. FULL→FULL on simultaneous drain and accept.

## Timing
- Reset values: out_valid=0; out_pc, op1, op2, rs2, rd, opcode, funct3, funct7 = 0. in_ready=1 once rst is low and no hazard.
- Latency: 1 cycle from in_valid&&in_ready to out_valid. Throughput: 1 instruction/cycle with no stalls.
- Payload is stable while out_valid && !out_ready.
- Combinational paths: ir→raddr; out_ready, ex_load, ex_rd, flush→in_ready; fwd_*, rdata→operand capture.
- rst asserted mid-stall or mid-backpressure drops the buffered instruction.

## Structure
- Package riscv holds:
  - op1_sel_t, op2_sel_t, ir_t, opcode_t, funct3_t, funct7_t, reg_t;
  - opcode constants OP_STORE and OP_BRANCH.
- XLEN-dependent types are local to the module.
- Sub-module imm_gen (parameter XLEN): input ir, outputs i/s/b/u/j immediates.

## Test plan
- rst high for 2 cycles → out_valid=0, all payload outputs 0, in_ready=1 afterwards.
- ir=32'hFFF08293 (addi x5,x1,-1), rdata1=10, op1_sel=RS1, op2_sel=I_IMM → next cycle out_valid=1, op1=10, op2=32'hFFFFFFFF, rd=5.
- fwd_valid=2'b11, both fwd_rd=1, fwd_data[0]=32'hAAAA, fwd_data[1]=32'hBBBB, rs1=1 → op1=32'hAAAA. Same with rs1=0 and fwd_rd=0 → op1=0.
- ex_load=1, ex_rd=3, ir=add x4,x3,x2 → in_ready=0 and out_valid=0 next cycle. Drop ex_load → accepted, out_valid=1 the cycle after.
- out_valid=1, out_ready=0 for 3 cycles → payload unchanged, in_ready=0. Then raise out_ready with in_valid=1 → back-to-back transfer.
- flush with out_valid=1, out_ready=0 → out_valid=0 next cycle. XLEN=64: lui with imm 20'h80000 → op2=64'hFFFFFFFF80000000.
